// File: rtl/nn_pkg.sv
// Shared types, default dimensions and helpers for the MLP layer sequencer.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef logic [1:0] layer_t;

    localparam int unsigned DEF_N0       = 64;
    localparam int unsigned DEF_N1       = 64;
    localparam int unsigned DEF_N2       = 22;
    localparam int unsigned DEF_M0       = 64;
    localparam int unsigned DEF_M1       = 64;
    localparam int unsigned DEF_M2       = 10;
    localparam int unsigned DEF_P        = 8;
    localparam int unsigned DEF_PIPE_LAT = 2;

    // Number of P-wide neuron groups needed to cover m outputs.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/nn_loop_counter.sv
// Zero-loadable up-counter that wraps to zero when it increments past its terminal value.
module nn_loop_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         at_last_c
);

    assign at_last_c = (cnt == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_last_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks the shared P-wide MAC pool over every neuron group of all three MLP layers.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned N0       = DEF_N0,
    parameter int unsigned N1       = DEF_N1,
    parameter int unsigned N2       = DEF_N2,
    parameter int unsigned M0       = DEF_M0,
    parameter int unsigned M1       = DEF_M1,
    parameter int unsigned M2       = DEF_M2,
    parameter int unsigned P        = DEF_P,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic               mac_clr,
    output logic               mac_en,
    output logic [CNT_W-1:0]   in_addr,
    output logic [WADDR_W-1:0] w_addr,
    output logic [1:0]         layer,
    output logic [CNT_W-1:0]   group,
    output logic               wr_en
);

    localparam int unsigned G0 = ceil_div(M0, P);
    localparam int unsigned G1 = ceil_div(M1, P);
    localparam int unsigned G2 = ceil_div(M2, P);

    localparam logic [CNT_W-1:0] N0_LAST    = CNT_W'(N0 - 1);
    localparam logic [CNT_W-1:0] N1_LAST    = CNT_W'(N1 - 1);
    localparam logic [CNT_W-1:0] N2_LAST    = CNT_W'(N2 - 1);
    localparam logic [CNT_W-1:0] G0_LAST    = CNT_W'(G0 - 1);
    localparam logic [CNT_W-1:0] G1_LAST    = CNT_W'(G1 - 1);
    localparam logic [CNT_W-1:0] G2_LAST    = CNT_W'(G2 - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam bit               HAS_DRAIN  = (PIPE_LAT != 0);

    state_t           state;
    state_t           state_nxt;
    logic             in_mac;
    logic [CNT_W-1:0] n_last;
    logic [CNT_W-1:0] g_last;
    logic [CNT_W-1:0] d_cnt;
    logic             i_last_c;
    logic             d_last_c;
    logic             g_last_c;
    logic             i_clr;
    logic             i_inc;
    logic             d_clr;
    logic             d_inc;
    logic             g_clr;
    logic             g_inc;

    // Per-layer loop bounds.
    always_comb begin
        case (layer)
            2'd0:    begin n_last = N0_LAST; g_last = G0_LAST; end
            2'd1:    begin n_last = N1_LAST; g_last = G1_LAST; end
            default: begin n_last = N2_LAST; g_last = G2_LAST; end
        endcase
    end

    always_comb begin
        i_clr = (state == ST_CLR);
        i_inc = (state == ST_MAC) && !hold;
        d_clr = (state != ST_DRAIN);
        d_inc = (state == ST_DRAIN);
        g_clr = (state == ST_IDLE);
        g_inc = (state == ST_WRITE);
    end

    nn_loop_counter #(.W(CNT_W)) u_in_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (i_clr),
        .inc       (i_inc),
        .last      (n_last),
        .cnt       (in_addr),
        .at_last_c (i_last_c)
    );

    nn_loop_counter #(.W(CNT_W)) u_drain_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (d_clr),
        .inc       (d_inc),
        .last      (DRAIN_LAST),
        .cnt       (d_cnt),
        .at_last_c (d_last_c)
    );

    nn_loop_counter #(.W(CNT_W)) u_group_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (g_clr),
        .inc       (g_inc),
        .last      (g_last),
        .cnt       (group),
        .at_last_c (g_last_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLR;
            ST_CLR:   state_nxt = ST_MAC;
            ST_MAC:   if (!hold && i_last_c) state_nxt = HAS_DRAIN ? ST_DRAIN : ST_WRITE;
            ST_DRAIN: if (d_last_c) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (!g_last_c || layer != 2'd2) ? ST_CLR : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded one cycle early from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_clr <= 1'b0;
            wr_en   <= 1'b0;
            in_mac  <= 1'b0;
            layer   <= 2'd0;
            w_addr  <= '0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            mac_clr <= (state_nxt == ST_CLR);
            wr_en   <= (state_nxt == ST_WRITE);
            in_mac  <= (state_nxt == ST_MAC);
            if (state == ST_MAC && !hold) begin
                w_addr <= w_addr + WADDR_W'(1);
            end else if (state == ST_DONE || state == ST_IDLE) begin
                w_addr <= '0;
            end
            if (state == ST_WRITE && g_last_c) begin
                layer <= (layer == 2'd2) ? 2'd0 : layer + 2'd1;
            end
        end
    end

    // hold must gate accumulation in the same cycle the memory reports not-ready.
    assign mac_en = in_mac && !hold;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized bench: a loop-level model of the layer/group/input walk predicts every cycle.
module tb_nn_layer_sequencer;

    localparam logic [38:0] M_ALL  = '1;
    localparam logic [38:0] M_NOIN = ~(39'hFF << 16);
    localparam logic [38:0] M_DONE = 39'h7C_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_v [3];
    logic        hold_v  [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        clr_w   [3];
    logic        en_w    [3];
    logic        wr_w    [3];
    logic [7:0]  in_w    [3];
    logic [15:0] wa_w    [3];
    logic [1:0]  lay_w   [3];
    logic [7:0]  grp_w   [3];
    logic [38:0] obs     [3];

    int checks = 0;
    int errors = 0;
    int stepno, n_clr, n_en, n_wr, last_wa, done_at;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < 3; c++)
            obs[c] = {busy_w[c], done_w[c], clr_w[c], en_w[c], wr_w[c],
                      lay_w[c], grp_w[c], in_w[c], wa_w[c]};
    end

    nn_layer_sequencer u_dut_def (
        .clk(clk), .rst(rst), .start(start_v[0]), .hold(hold_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .mac_clr(clr_w[0]), .mac_en(en_w[0]),
        .in_addr(in_w[0]), .w_addr(wa_w[0]), .layer(lay_w[0]), .group(grp_w[0]),
        .wr_en(wr_w[0])
    );

    nn_layer_sequencer #(.N0(3), .N1(3), .N2(3), .M0(2), .M1(2), .M2(2), .P(2),
                         .PIPE_LAT(1)) u_dut_small (
        .clk(clk), .rst(rst), .start(start_v[1]), .hold(hold_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .mac_clr(clr_w[1]), .mac_en(en_w[1]),
        .in_addr(in_w[1]), .w_addr(wa_w[1]), .layer(lay_w[1]), .group(grp_w[1]),
        .wr_en(wr_w[1])
    );

    nn_layer_sequencer #(.N0(5), .N1(4), .N2(3), .M0(16), .M1(8), .M2(10), .P(8),
                         .PIPE_LAT(0)) u_dut_nolat (
        .clk(clk), .rst(rst), .start(start_v[2]), .hold(hold_v[2]),
        .busy(busy_w[2]), .done(done_w[2]), .mac_clr(clr_w[2]), .mac_en(en_w[2]),
        .in_addr(in_w[2]), .w_addr(wa_w[2]), .layer(lay_w[2]), .group(grp_w[2]),
        .wr_en(wr_w[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [38:0] mk(input bit b, input bit d, input bit cl, input bit en,
                                       input bit wr, input int l, input int g, input int i,
                                       input int wa);
        return {b, d, cl, en, wr, 2'(l), 8'(g), 8'(i), 16'(wa)};
    endfunction

    // One clock cycle: inputs already driven, compare mid-cycle, move to just after the next edge.
    task automatic step(input int c, input logic [38:0] exp, input logic [38:0] msk,
                        input string tag);
        @(negedge clk);
        chk(tag, 64'(obs[c] & msk), 64'(exp & msk));
        if (obs[c][36]) n_clr++;
        if (obs[c][35]) begin n_en++; last_wa = int'(obs[c][15:0]); end
        if (obs[c][34]) n_wr++;
        if (obs[c][37] && done_at < 0) done_at = stepno;
        stepno++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_busy(input int c, input bit keep_start);
        start_v[c] = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
        hold_v[c]  = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int c, input int n0, input int n1, input int n2,
                       input int g0, input int g1, input int g2, input int pl,
                       input int hold_pct, input bit keep_start, input bit burst,
                       input bit abort, input string name);
        int n [3];
        int g [3];
        int wa, holds, burst_left, total_en, total_grp, t_exp;
        bit h;
        n = '{n0, n1, n2};
        g = '{g0, g1, g2};
        wa = 0; holds = 0; burst_left = 0;
        stepno = 0; n_clr = 0; n_en = 0; n_wr = 0; last_wa = -1; done_at = -1;
        start_v[c] = 1'b1;
        hold_v[c]  = 1'($urandom_range(0, 1));
        step(c, '0, M_ALL, {name, "_idle"});
        for (int l = 0; l < 3; l++) begin
            for (int gi = 0; gi < g[l]; gi++) begin
                drive_busy(c, keep_start);
                step(c, mk(1, 0, 1, 0, 0, l, gi, 0, wa), M_NOIN, {name, "_clr"});
                for (int i = 0; i < n[l]; i++) begin
                    if (burst && l == 1 && gi == 0 && i == n[1] / 2) burst_left = 5;
                    forever begin
                        h = (burst_left > 0) ? 1'b1 : ($urandom_range(0, 99) < hold_pct);
                        if (burst_left > 0) burst_left--;
                        start_v[c] = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
                        hold_v[c]  = h;
                        step(c, mk(1, 0, 0, !h, 0, l, gi, i, wa), M_ALL, {name, "_mac"});
                        if (!h) break;
                        holds++;
                    end
                    wa++;
                end
                for (int d = 0; d < pl; d++) begin
                    drive_busy(c, keep_start);
                    if (abort && l == 1 && gi == 0) begin
                        rst = 1'b1;
                        step(c, mk(1, 0, 0, 0, 0, l, gi, 0, wa), M_NOIN, {name, "_drain"});
                        rst = 1'b0;
                        start_v[c] = 1'b0;
                        step(c, '0, M_ALL, {name, "_rst_idle"});
                        chk({name, "_abort_done"}, 64'(done_at), 64'(-1));
                        return;
                    end
                    step(c, mk(1, 0, 0, 0, 0, l, gi, 0, wa), M_NOIN, {name, "_drain"});
                end
                drive_busy(c, keep_start);
                step(c, mk(1, 0, 0, 0, 1, l, gi, 0, wa), M_NOIN, {name, "_write"});
            end
        end
        start_v[c] = keep_start;
        hold_v[c]  = 1'($urandom_range(0, 1));
        step(c, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), M_DONE, {name, "_done"});
        total_en  = g0 * n0 + g1 * n1 + g2 * n2;
        total_grp = g0 + g1 + g2;
        t_exp = 1 + g0 * (n0 + pl + 2) + g1 * (n1 + pl + 2) + g2 * (n2 + pl + 2) + holds;
        chk({name, "_done_cycle"}, 64'(done_at), 64'(t_exp));
        chk({name, "_n_clr"}, 64'(n_clr), 64'(total_grp));
        chk({name, "_n_en"}, 64'(n_en), 64'(total_en));
        chk({name, "_n_wr"}, 64'(n_wr), 64'(total_grp));
        chk({name, "_last_waddr"}, 64'(last_wa), 64'(total_en - 1));
    endtask

    initial begin
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            start_v[c] = 1'b0;
            hold_v[c]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) chk("reset_state", 64'(obs[c]), 64'd0);
        @(posedge clk);
        #1;

        // Defaults: baseline, 5-cycle hold burst in layer 1, random traffic, abort and rerun.
        run(0, 64, 64, 22, 8, 8, 2, 2, 0, 1'b0, 1'b0, 1'b0, "base");
        chk("base_done_1141", 64'(done_at), 64'd1141);
        run(0, 64, 64, 22, 8, 8, 2, 2, 0, 1'b0, 1'b1, 1'b0, "burst");
        chk("burst_done_1146", 64'(done_at), 64'd1146);
        run(0, 64, 64, 22, 8, 8, 2, 2, 20, 1'b0, 1'b0, 1'b0, "rand");
        run(0, 64, 64, 22, 8, 8, 2, 2, 10, 1'b0, 1'b0, 1'b1, "abort");
        run(0, 64, 64, 22, 8, 8, 2, 2, 0, 1'b0, 1'b0, 1'b0, "rerun");
        step(0, '0, M_ALL, "def_post_idle");

        // Small config with start held high: back-to-back runs separated by one IDLE.
        for (int r = 0; r < 3; r++)
            run(1, 3, 3, 3, 1, 1, 1, 1, 25, 1'b1, 1'b0, 1'b0, "small_cont");
        run(1, 3, 3, 3, 1, 1, 1, 1, 25, 1'b0, 1'b0, 1'b0, "small_last");
        start_v[1] = 1'b0;
        step(1, '0, M_ALL, "small_post_idle");

        // Partial last group in layer 2 and no drain stage.
        run(2, 5, 4, 3, 2, 1, 2, 0, 0, 1'b0, 1'b0, 1'b0, "nolat");
        run(2, 5, 4, 3, 2, 1, 2, 0, 30, 1'b0, 1'b0, 1'b0, "nolat_rand");
        step(2, '0, M_ALL, "nolat_post_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
